seq_mult_32b: RTL and testbench

Sequential unsigned 32x32 shift-add multiplier for the 32-bit ALU. It computes a 64-bit product over 32 clock cycles and holds the result on two 32-bit words. `prod_lo` feeds one data input of the 4:1 32-bit result mux. `prod_hi` is available to a second mux input or a high-word read path. A start/busy/done handshake lets the ALU control sequence multiply operations alongside the single-cycle combinational ops.

---
 rtl/seq_mult_32b.sv | 94 +++++++++
 tb/tb_seq_mult_32b.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/seq_mult_32b.sv
// Sequential unsigned shift-add multiplier: WIDTH x WIDTH -> 2*WIDTH product over WIDTH cycles.
// Start/busy/done handshake; the product words hold until the next completion or reset.
module seq_mult_32b #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] prod_lo,
    output logic [WIDTH-1:0] prod_hi
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] w_addend;
    logic [2*WIDTH-1:0] w_acc_next;
    logic               w_last;

    always_comb begin
        w_last     = (r_cnt == CW'(WIDTH - 1));
        w_addend   = r_mplier[0] ? ({{WIDTH{1'b0}}, r_mcand} << r_cnt) : '0;
        w_acc_next = r_acc + w_addend;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_BUSY;
            S_BUSY:  if (w_last) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_acc    <= '0;
            prod_lo  <= '0;
            prod_hi  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mcand  <= a;
                        r_mplier <= b;
                        r_cnt    <= '0;
                        r_acc    <= '0;
                    end
                end
                S_BUSY: begin
                    r_acc    <= w_acc_next;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                    // Final partial product is folded in on the same edge that publishes the result.
                    if (w_last) begin
                        {prod_hi, prod_lo} <= w_acc_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state == S_BUSY);
    assign done = (r_state == S_DONE);

endmodule

// File: tb/tb_seq_mult_32b.sv
// Bench for seq_mult_32b: a cycle-level reference model checked every cycle,
// plus directed operations with hand-computed products.
module tb_seq_mult_32b;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy;
    logic        done;
    logic [31:0] prod_lo;
    logic [31:0] prod_hi;

    int n_checks = 0;
    int n_errs   = 0;

    seq_mult_32b #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .prod_lo(prod_lo), .prod_hi(prod_hi)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: m_cnt = cycles since the accepted start (-1 when idle).
    int          m_cnt  = -1;
    logic        m_init = 1'b0;
    logic [63:0] m_pend = '0;
    logic [63:0] m_prod = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_cnt  <= -1;
            m_prod <= '0;
            m_init <= 1'b1;
        end else if (m_cnt < 0) begin
            if (start) begin
                m_cnt  <= 0;
                m_pend <= {32'b0, a} * {32'b0, b};
            end
        end else begin
            if (m_cnt == 31) m_prod <= m_pend;
            m_cnt <= (m_cnt == 32) ? -1 : m_cnt + 1;
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            chk("model_busy", 64'(busy), 64'(m_cnt >= 0 && m_cnt <= 31));
            chk("model_done", 64'(done), 64'(m_cnt == 32));
            chk("model_prod", {prod_hi, prod_lo}, m_prod);
        end
    end

    // Waits for done; reports the number of busy cycles seen before it.
    task automatic wait_done(input string name, output int busy_cycles);
        bit seen = 1'b0;
        busy_cycles = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (busy) busy_cycles++;
            if (done) seen = 1'b1;
        end
        if (!seen) chk({name, "_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic pulse_start(input logic [31:0] av, input logic [31:0] bv);
        @(negedge clk);
        a = av; b = bv; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom;
    endtask

    task automatic run_op(input string name, input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] ehi, input logic [31:0] elo);
        int bc;
        pulse_start(av, bv);
        wait_done(name, bc);
        chk({name, "_busycyc"}, 64'(bc + 1), 64'd32);
        chk({name, "_hi"}, 64'(prod_hi), 64'(ehi));
        chk({name, "_lo"}, 64'(prod_lo), 64'(elo));
    endtask

    initial begin
        int bc;
        int ndone;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_prod", {prod_hi, prod_lo}, 64'd0);

        run_op("mul_3x5", 32'd3, 32'd5, 32'h0, 32'hF);
        run_op("mul_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("mul_x10", 32'h1234_5678, 32'h10, 32'h1, 32'h2345_6780);

        // Zero multiplier: previous product must hold until this operation completes.
        pulse_start(32'h1234_5678, 32'h0);
        repeat (15) @(negedge clk);
        chk("hold_lo", 64'(prod_lo), 64'h2345_6780);
        wait_done("mul_zero", bc);
        chk("mul_zero_prod", {prod_hi, prod_lo}, 64'd0);

        // Start asserted mid-iteration is ignored.
        @(negedge clk);
        a = 32'd7; b = 32'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        a = 32'hFFFF_FFFF; b = 32'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("ignore", bc);
        chk("ignore_busycyc", 64'(bc + 1 + 10), 64'd32);
        chk("ignore_prod", {prod_hi, prod_lo}, 64'h3F);

        // Reset in the middle of an operation aborts it.
        pulse_start(32'h1000_0000, 32'h10);
        repeat (14) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_prod", {prod_hi, prod_lo}, 64'd0);
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("abort_no_done", 64'(ndone), 64'd0);
        run_op("after_abort", 32'h1000_0000, 32'h10, 32'h1, 32'h0);

        // Start held high: repeated multiplies, each publishing 12.
        @(negedge clk);
        a = 32'd2; b = 32'd6; start = 1'b1;
        ndone = 0;
        repeat (140) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                chk("b2b_lo", 64'(prod_lo), 64'hC);
                chk("b2b_hi", 64'(prod_hi), 64'h0);
            end
        end
        start = 1'b0;
        chk("b2b_count_min", 64'(ndone >= 3), 64'd1);

        repeat (40) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
